mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_id_fifo.sv | 53 +++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-system definitions: port identifiers, bus widths and
// default sizing for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_BURST = 4;

    typedef enum logic {
        P_IMEM = 1'b0,
        P_DMEM = 1'b1
    } port_id_e;

    function automatic port_id_e other_port(input port_id_e id);
        return (id == P_IMEM) ? P_DMEM : P_IMEM;
    endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory reads.
// Push on full and pop on empty are ignored, so the pointers can never wrap past each other.
module id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) memory arbiter: burst-limited round-robin issue,
// zero-latency forwarding, in-order read-response routing by tracked IDs.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int BURST = DEF_BURST
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    output logic              o_p0_ready,
    input  logic [ADDR_W-1:0] i_p0_addr,
    input  logic              i_p0_ren,
    input  logic              i_p0_wen,
    input  logic [DATA_W-1:0] i_p0_wdata,
    output logic [DATA_W-1:0] o_p0_rdata,
    output logic              o_p0_valid,

    output logic              o_p1_ready,
    input  logic [ADDR_W-1:0] i_p1_addr,
    input  logic              i_p1_ren,
    input  logic              i_p1_wen,
    input  logic [DATA_W-1:0] i_p1_wdata,
    output logic [DATA_W-1:0] o_p1_rdata,
    output logic              o_p1_valid,

    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid,

    output logic              o_err
);

    localparam int CNT_W = $clog2(BURST + 1);

    port_id_e         owner_q;
    port_id_e         owner_d;
    logic [CNT_W-1:0] burst_q;
    logic [CNT_W-1:0] burst_d;
    logic             err_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [0:0]       fifo_head;
    logic [0:0]       fifo_din;
    port_id_e         head_id;

    logic             owner_ready;
    logic             owner_ren;
    logic             owner_wen;
    logic             issue_rd;
    logic             issue_wr;
    logic             issue;
    logic             resp_ok;

    // Ready depends only on registered state and i_mem_ready, never on request strobes.
    assign owner_ready = i_mem_ready && !fifo_full;
    assign o_p0_ready  = owner_ready && (owner_q == P_IMEM);
    assign o_p1_ready  = owner_ready && (owner_q == P_DMEM);

    always_comb begin
        owner_ren   = i_p0_ren;
        owner_wen   = i_p0_wen;
        o_mem_addr  = i_p0_addr;
        o_mem_wdata = i_p0_wdata;
        if (owner_q == P_DMEM) begin
            owner_ren   = i_p1_ren;
            owner_wen   = i_p1_wen;
            o_mem_addr  = i_p1_addr;
            o_mem_wdata = i_p1_wdata;
        end
    end

    assign issue_rd  = owner_ready && owner_ren;
    assign issue_wr  = owner_ready && owner_wen;
    assign issue     = issue_rd || issue_wr;
    assign o_mem_ren = issue_rd;
    assign o_mem_wen = issue_wr;

    // Ownership passes on an idle owner cycle or when the burst allowance is used up.
    always_comb begin
        owner_d = owner_q;
        burst_d = burst_q;
        if (!issue || (burst_q == CNT_W'(BURST - 1))) begin
            owner_d = other_port(owner_q);
            burst_d = '0;
        end else begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q <= P_IMEM;
            burst_q <= '0;
        end else begin
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    assign fifo_din = owner_q;

    id_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (issue_rd),
        .i_pop   (i_mem_valid),
        .i_din   (fifo_din),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign head_id    = port_id_e'(fifo_head);
    assign resp_ok    = i_mem_valid && !fifo_empty;
    assign o_p0_valid = resp_ok && (head_id == P_IMEM);
    assign o_p1_valid = resp_ok && (head_id == P_DMEM);
    assign o_p0_rdata = i_mem_rdata;
    assign o_p1_rdata = i_mem_rdata;

    // A response with nothing outstanding is a protocol error; it sticks until reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (i_mem_valid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;

endmodule
